// File: rtl/id_stage.sv
// RV32I/RV64I instruction-decode pipeline stage with valid/ready handshakes on both sides,
// a registered decode bundle, and a halt/trap state machine (ebreak halts, illegal encodings trap).
module id_stage #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ALU_OP_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_valid,
    output logic                      if_ready,
    input  logic [31:0]               if_inst,
    input  logic [XLEN-1:0]           if_pc,
    input  logic                      flush,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [XLEN-1:0]           id_pc,
    output logic [REG_ADDR_WIDTH-1:0] id_rs1,
    output logic [REG_ADDR_WIDTH-1:0] id_rs2,
    output logic [REG_ADDR_WIDTH-1:0] id_rd,
    output logic                      id_reg_wen,
    output logic [ALU_OP_WIDTH-1:0]   id_alu_op,
    output logic [2:0]                id_imm_sel,
    output logic [1:0]                id_src_sel,
    output logic                      id_branch,
    output logic                      id_jump,
    output logic                      id_jalr,
    output logic [2:0]                id_br_fn,
    output logic                      id_mem_ren,
    output logic                      id_mem_wen,
    output logic [1:0]                id_mem_size,
    output logic                      id_mem_uns,
    output logic                      id_word_op,
    output logic                      halt,
    output logic                      trap,
    output logic [31:0]               trap_inst
);
    localparam bit RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = ALU_OP_WIDTH'(9);

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] SRC_REG     = 2'd0;
    localparam logic [1:0] SRC_IMM     = 2'd1;
    localparam logic [1:0] SRC_IMM_PC  = 2'd2;
    localparam logic [1:0] SRC_FOUR_PC = 2'd3;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   accept;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [REG_ADDR_WIDTH-1:0] f_rs1, f_rs2, f_rd;
    logic shimm_ok;

    logic d_illegal, d_ebreak, use_rs1, use_rs2, use_rd;
    logic [REG_ADDR_WIDTH-1:0] d_rs1, d_rs2, d_rd;
    logic d_wen, d_branch, d_jump, d_jalr, d_ren, d_mwen, d_uns, d_word;
    logic [ALU_OP_WIDTH-1:0] d_alu;
    logic [2:0] d_imm, d_br_fn;
    logic [1:0] d_src, d_size;

    function automatic logic [ALU_OP_WIDTH-1:0] alu_of(input logic [2:0] fn, input logic alt);
        logic [ALU_OP_WIDTH-1:0] op;
        op = ALU_ADD;
        case (fn)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
        endcase
        return op;
    endfunction

    assign opcode = if_inst[6:0];
    assign f3     = if_inst[14:12];
    assign f7     = if_inst[31:25];
    assign f_rd   = REG_ADDR_WIDTH'(if_inst[11:7]);
    assign f_rs1  = REG_ADDR_WIDTH'(if_inst[19:15]);
    assign f_rs2  = REG_ADDR_WIDTH'(if_inst[24:20]);

    // Shift-immediate: bit 25 is shamt[5], only meaningful on RV64; bit 30 selects arithmetic right shift
    assign shimm_ok = ((if_inst[31:26] == 6'b000000) ||
                       (f3 == 3'b101 && if_inst[31:26] == 6'b010000)) &&
                      (RV64 || !if_inst[25]);

    assign if_ready = (state_q == S_RUN) && !flush && (!id_valid || id_ready);
    assign accept   = if_valid && if_ready;

    // Instruction decode
    always_comb begin
        d_illegal = 1'b0;
        d_ebreak  = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        d_alu     = ALU_ADD;
        d_imm     = IMM_I;
        d_src     = SRC_REG;
        d_branch  = 1'b0;
        d_jump    = 1'b0;
        d_jalr    = 1'b0;
        d_br_fn   = 3'b000;
        d_ren     = 1'b0;
        d_mwen    = 1'b0;
        d_size    = 2'b00;
        d_uns     = 1'b0;
        d_word    = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                use_rd = 1'b1; d_imm = IMM_U; d_src = SRC_IMM;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1; d_imm = IMM_U; d_src = SRC_IMM_PC;
            end
            OPC_JAL: begin
                use_rd = 1'b1; d_imm = IMM_J; d_src = SRC_FOUR_PC; d_jump = 1'b1;
            end
            OPC_JALR: begin
                d_illegal = (f3 != 3'b000);
                use_rd = 1'b1; use_rs1 = 1'b1; d_imm = IMM_I; d_src = SRC_FOUR_PC;
                d_jump = 1'b1; d_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                d_illegal = (f3 == 3'b010) || (f3 == 3'b011);
                use_rs1 = 1'b1; use_rs2 = 1'b1; d_imm = IMM_B; d_alu = ALU_SUB;
                d_branch = 1'b1; d_br_fn = f3;
            end
            OPC_LOAD: begin
                d_illegal = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
                use_rd = 1'b1; use_rs1 = 1'b1; d_imm = IMM_I; d_src = SRC_IMM;
                d_ren = 1'b1; d_size = f3[1:0]; d_uns = f3[2];
            end
            OPC_STORE: begin
                d_illegal = f3[2] || (!RV64 && f3 == 3'b011);
                use_rs1 = 1'b1; use_rs2 = 1'b1; d_imm = IMM_S; d_src = SRC_IMM;
                d_mwen = 1'b1; d_size = f3[1:0];
            end
            OPC_OPIMM: begin
                d_illegal = (f3[1:0] == 2'b01) && !shimm_ok;
                use_rd = 1'b1; use_rs1 = 1'b1; d_imm = IMM_I; d_src = SRC_IMM;
                d_alu = alu_of(f3, (f3 == 3'b101) && if_inst[30]);
            end
            OPC_OP: begin
                d_illegal = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                d_alu = alu_of(f3, f7[5]);
            end
            OPC_OPIMM32: begin
                d_illegal = !RV64 || !((f3 == 3'b000) || (f3 == 3'b001 && f7 == 7'h00) ||
                                       (f3 == 3'b101 && (f7 == 7'h00 || f7 == 7'h20)));
                use_rd = 1'b1; use_rs1 = 1'b1; d_imm = IMM_I; d_src = SRC_IMM; d_word = 1'b1;
                d_alu = alu_of(f3, (f3 == 3'b101) && if_inst[30]);
            end
            OPC_OP32: begin
                d_illegal = !RV64 || !(((f3 == 3'b000 || f3 == 3'b101) && (f7 == 7'h00 || f7 == 7'h20)) ||
                                       (f3 == 3'b001 && f7 == 7'h00));
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d_word = 1'b1;
                d_alu = alu_of(f3, f7[5]);
            end
            OPC_SYSTEM: begin
                d_ebreak  = (if_inst == INST_EBREAK);
                d_illegal = (if_inst != INST_EBREAK);
            end
            default: d_illegal = 1'b1;
        endcase
        d_rs1 = use_rs1 ? f_rs1 : '0;
        d_rs2 = use_rs2 ? f_rs2 : '0;
        d_wen = use_rd && (f_rd != '0);
        d_rd  = d_wen ? f_rd : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    // HALT and TRAP are sticky until reset
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (d_ebreak)       state_d = S_HALT;
            else if (d_illegal) state_d = S_TRAP;
        end
    end

    // Bundle register: loads only on a legal accept; flush wins over hold and drain
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_rs1      <= '0;
            id_rs2      <= '0;
            id_rd       <= '0;
            id_reg_wen  <= 1'b0;
            id_alu_op   <= '0;
            id_imm_sel  <= 3'd0;
            id_src_sel  <= 2'd0;
            id_branch   <= 1'b0;
            id_jump     <= 1'b0;
            id_jalr     <= 1'b0;
            id_br_fn    <= 3'd0;
            id_mem_ren  <= 1'b0;
            id_mem_wen  <= 1'b0;
            id_mem_size <= 2'd0;
            id_mem_uns  <= 1'b0;
            id_word_op  <= 1'b0;
            halt        <= 1'b0;
            trap        <= 1'b0;
            trap_inst   <= 32'd0;
        end else begin
            if (flush) begin
                id_valid <= 1'b0;
            end else if (accept && !d_illegal) begin
                id_valid    <= 1'b1;
                id_pc       <= if_pc;
                id_rs1      <= d_rs1;
                id_rs2      <= d_rs2;
                id_rd       <= d_rd;
                id_reg_wen  <= d_wen;
                id_alu_op   <= d_alu;
                id_imm_sel  <= d_imm;
                id_src_sel  <= d_src;
                id_branch   <= d_branch;
                id_jump     <= d_jump;
                id_jalr     <= d_jalr;
                id_br_fn    <= d_br_fn;
                id_mem_ren  <= d_ren;
                id_mem_wen  <= d_mwen;
                id_mem_size <= d_size;
                id_mem_uns  <= d_uns;
                id_word_op  <= d_word;
            end else if (id_ready || accept) begin
                id_valid <= 1'b0;
            end
            halt <= (state_d == S_HALT);
            trap <= (state_d == S_TRAP);
            if (accept && d_illegal) trap_inst <= if_inst;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: RV64 and RV32 instances share stimulus; a mask/match opcode-table model predicts both.
module tb_id_stage;
    localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LD = 5,
                   K_ST = 6, K_OPI = 7, K_OP = 8, K_EBRK = 9;
    localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4, A_SLL = 5,
                   A_SRL = 6, A_SRA = 7, A_SLT = 8, A_SLTU = 9;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int xl;
        int kind;
        int alu;
        int sz;
        bit uns;
        bit word;
    } ent_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  alu;
        logic [2:0]  imm;
        logic [1:0]  src;
        logic        br;
        logic        jmp;
        logic        jalr;
        logic [2:0]  fn;
        logic        ren;
        logic        mwen;
        logic [1:0]  sz;
        logic        uns;
        logic        word;
    } bun_t;

    logic clk, rst, if_valid, flush, id_ready;
    logic [31:0] if_inst;
    logic [63:0] if_pc;

    logic a_if_ready, a_id_valid, a_wen, a_br, a_jmp, a_jalr, a_ren, a_mwen, a_uns, a_word, a_halt, a_trap;
    logic [63:0] a_pc;
    logic [4:0] a_rs1, a_rs2, a_rd;
    logic [3:0] a_alu;
    logic [2:0] a_imm, a_fn;
    logic [1:0] a_src, a_sz;
    logic [31:0] a_trap_inst;

    logic b_if_ready, b_id_valid, b_wen, b_br, b_jmp, b_jalr, b_ren, b_mwen, b_uns, b_word, b_halt, b_trap;
    logic [31:0] b_pc;
    logic [4:0] b_rs1, b_rs2, b_rd;
    logic [3:0] b_alu;
    logic [2:0] b_imm, b_fn;
    logic [1:0] b_src, b_sz;
    logic [31:0] b_trap_inst;

    bun_t o_a, o_b;
    assign o_a = {a_pc, a_rs1, a_rs2, a_rd, a_wen, a_alu, a_imm, a_src, a_br, a_jmp, a_jalr,
                  a_fn, a_ren, a_mwen, a_sz, a_uns, a_word};
    assign o_b = {32'd0, b_pc, b_rs1, b_rs2, b_rd, b_wen, b_alu, b_imm, b_src, b_br, b_jmp, b_jalr,
                  b_fn, b_ren, b_mwen, b_sz, b_uns, b_word};

    id_stage #(.XLEN(64), .REG_ADDR_WIDTH(5), .ALU_OP_WIDTH(4)) dut64 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(a_if_ready), .if_inst(if_inst),
        .if_pc(if_pc), .flush(flush), .id_valid(a_id_valid), .id_ready(id_ready), .id_pc(a_pc),
        .id_rs1(a_rs1), .id_rs2(a_rs2), .id_rd(a_rd), .id_reg_wen(a_wen), .id_alu_op(a_alu),
        .id_imm_sel(a_imm), .id_src_sel(a_src), .id_branch(a_br), .id_jump(a_jmp), .id_jalr(a_jalr),
        .id_br_fn(a_fn), .id_mem_ren(a_ren), .id_mem_wen(a_mwen), .id_mem_size(a_sz),
        .id_mem_uns(a_uns), .id_word_op(a_word), .halt(a_halt), .trap(a_trap), .trap_inst(a_trap_inst));

    id_stage #(.XLEN(32), .REG_ADDR_WIDTH(5), .ALU_OP_WIDTH(4)) dut32 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(b_if_ready), .if_inst(if_inst),
        .if_pc(if_pc[31:0]), .flush(flush), .id_valid(b_id_valid), .id_ready(id_ready), .id_pc(b_pc),
        .id_rs1(b_rs1), .id_rs2(b_rs2), .id_rd(b_rd), .id_reg_wen(b_wen), .id_alu_op(b_alu),
        .id_imm_sel(b_imm), .id_src_sel(b_src), .id_branch(b_br), .id_jump(b_jmp), .id_jalr(b_jalr),
        .id_br_fn(b_fn), .id_mem_ren(b_ren), .id_mem_wen(b_mwen), .id_mem_size(b_sz),
        .id_mem_uns(b_uns), .id_word_op(b_word), .halt(b_halt), .trap(b_trap), .trap_inst(b_trap_inst));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    ent_t tab[$];
    int m_st[2];            // 0 run, 1 halted, 2 trapped
    bit m_v[2];
    bun_t m_b[2];
    logic [31:0] m_ti[2];
    bit known = 0;

    function automatic void add(input logic [31:0] mask, input logic [31:0] match, input int xl,
                                input int kind, input int alu, input int sz, input bit uns, input bit word);
        ent_t e;
        e.mask = mask; e.match = match; e.xl = xl; e.kind = kind;
        e.alu = alu; e.sz = sz; e.uns = uns; e.word = word;
        tab.push_back(e);
    endfunction

    task automatic build_table();
        add(32'h7f, 32'h37, 0, K_LUI, A_ADD, 0, 0, 0);
        add(32'h7f, 32'h17, 0, K_AUIPC, A_ADD, 0, 0, 0);
        add(32'h7f, 32'h6f, 0, K_JAL, A_ADD, 0, 0, 0);
        add(32'h707f, 32'h67, 0, K_JALR, A_ADD, 0, 0, 0);
        add(32'h707f, 32'h0063, 0, K_BR, A_SUB, 0, 0, 0);
        add(32'h707f, 32'h1063, 0, K_BR, A_SUB, 0, 0, 0);
        add(32'h707f, 32'h4063, 0, K_BR, A_SUB, 0, 0, 0);
        add(32'h707f, 32'h5063, 0, K_BR, A_SUB, 0, 0, 0);
        add(32'h707f, 32'h6063, 0, K_BR, A_SUB, 0, 0, 0);
        add(32'h707f, 32'h7063, 0, K_BR, A_SUB, 0, 0, 0);
        add(32'h707f, 32'h0003, 0, K_LD, A_ADD, 0, 0, 0);
        add(32'h707f, 32'h1003, 0, K_LD, A_ADD, 1, 0, 0);
        add(32'h707f, 32'h2003, 0, K_LD, A_ADD, 2, 0, 0);
        add(32'h707f, 32'h3003, 64, K_LD, A_ADD, 3, 0, 0);
        add(32'h707f, 32'h4003, 0, K_LD, A_ADD, 0, 1, 0);
        add(32'h707f, 32'h5003, 0, K_LD, A_ADD, 1, 1, 0);
        add(32'h707f, 32'h6003, 64, K_LD, A_ADD, 2, 1, 0);
        add(32'h707f, 32'h0023, 0, K_ST, A_ADD, 0, 0, 0);
        add(32'h707f, 32'h1023, 0, K_ST, A_ADD, 1, 0, 0);
        add(32'h707f, 32'h2023, 0, K_ST, A_ADD, 2, 0, 0);
        add(32'h707f, 32'h3023, 64, K_ST, A_ADD, 3, 0, 0);
        add(32'h707f, 32'h0013, 0, K_OPI, A_ADD, 0, 0, 0);
        add(32'h707f, 32'h2013, 0, K_OPI, A_SLT, 0, 0, 0);
        add(32'h707f, 32'h3013, 0, K_OPI, A_SLTU, 0, 0, 0);
        add(32'h707f, 32'h4013, 0, K_OPI, A_XOR, 0, 0, 0);
        add(32'h707f, 32'h6013, 0, K_OPI, A_OR, 0, 0, 0);
        add(32'h707f, 32'h7013, 0, K_OPI, A_AND, 0, 0, 0);
        add(32'hfe00707f, 32'h00001013, 32, K_OPI, A_SLL, 0, 0, 0);
        add(32'hfe00707f, 32'h00005013, 32, K_OPI, A_SRL, 0, 0, 0);
        add(32'hfe00707f, 32'h40005013, 32, K_OPI, A_SRA, 0, 0, 0);
        add(32'hfc00707f, 32'h00001013, 64, K_OPI, A_SLL, 0, 0, 0);
        add(32'hfc00707f, 32'h00005013, 64, K_OPI, A_SRL, 0, 0, 0);
        add(32'hfc00707f, 32'h40005013, 64, K_OPI, A_SRA, 0, 0, 0);
        add(32'hfe00707f, 32'h00000033, 0, K_OP, A_ADD, 0, 0, 0);
        add(32'hfe00707f, 32'h40000033, 0, K_OP, A_SUB, 0, 0, 0);
        add(32'hfe00707f, 32'h00001033, 0, K_OP, A_SLL, 0, 0, 0);
        add(32'hfe00707f, 32'h00002033, 0, K_OP, A_SLT, 0, 0, 0);
        add(32'hfe00707f, 32'h00003033, 0, K_OP, A_SLTU, 0, 0, 0);
        add(32'hfe00707f, 32'h00004033, 0, K_OP, A_XOR, 0, 0, 0);
        add(32'hfe00707f, 32'h00005033, 0, K_OP, A_SRL, 0, 0, 0);
        add(32'hfe00707f, 32'h40005033, 0, K_OP, A_SRA, 0, 0, 0);
        add(32'hfe00707f, 32'h00006033, 0, K_OP, A_OR, 0, 0, 0);
        add(32'hfe00707f, 32'h00007033, 0, K_OP, A_AND, 0, 0, 0);
        add(32'h707f, 32'h001b, 64, K_OPI, A_ADD, 0, 0, 1);
        add(32'hfe00707f, 32'h0000101b, 64, K_OPI, A_SLL, 0, 0, 1);
        add(32'hfe00707f, 32'h0000501b, 64, K_OPI, A_SRL, 0, 0, 1);
        add(32'hfe00707f, 32'h4000501b, 64, K_OPI, A_SRA, 0, 0, 1);
        add(32'hfe00707f, 32'h0000003b, 64, K_OP, A_ADD, 0, 0, 1);
        add(32'hfe00707f, 32'h4000003b, 64, K_OP, A_SUB, 0, 0, 1);
        add(32'hfe00707f, 32'h0000103b, 64, K_OP, A_SLL, 0, 0, 1);
        add(32'hfe00707f, 32'h0000503b, 64, K_OP, A_SRL, 0, 0, 1);
        add(32'hfe00707f, 32'h4000503b, 64, K_OP, A_SRA, 0, 0, 1);
        add(32'hffffffff, 32'h00100073, 0, K_EBRK, A_ADD, 0, 0, 0);
    endtask

    function automatic int lookup(input logic [31:0] i, input int xl);
        foreach (tab[j])
            if ((i & tab[j].mask) == tab[j].match && (tab[j].xl == 0 || tab[j].xl == xl)) return j;
        return -1;
    endfunction

    function automatic bun_t expect_of(input ent_t e, input logic [31:0] i, input logic [63:0] pc);
        bun_t b;
        bit r1, r2, wr;
        b = '0;
        b.pc = pc;
        if (e.kind == K_EBRK) return b;
        r1 = e.kind inside {K_JALR, K_BR, K_LD, K_ST, K_OPI, K_OP};
        r2 = e.kind inside {K_BR, K_ST, K_OP};
        wr = e.kind inside {K_LUI, K_AUIPC, K_JAL, K_JALR, K_LD, K_OPI, K_OP};
        b.rs1 = r1 ? i[19:15] : 5'd0;
        b.rs2 = r2 ? i[24:20] : 5'd0;
        b.wen = wr && (i[11:7] != 5'd0);
        b.rd  = b.wen ? i[11:7] : 5'd0;
        b.alu = 4'(e.alu);
        case (e.kind)
            K_LUI:   begin b.imm = 3'd3; b.src = 2'd1; end
            K_AUIPC: begin b.imm = 3'd3; b.src = 2'd2; end
            K_JAL:   begin b.imm = 3'd4; b.src = 2'd3; b.jmp = 1'b1; end
            K_JALR:  begin b.imm = 3'd0; b.src = 2'd3; b.jmp = 1'b1; b.jalr = 1'b1; end
            K_BR:    begin b.imm = 3'd2; b.src = 2'd0; b.br = 1'b1; b.fn = i[14:12]; end
            K_LD:    begin b.imm = 3'd0; b.src = 2'd1; b.ren = 1'b1; end
            K_ST:    begin b.imm = 3'd1; b.src = 2'd1; b.mwen = 1'b1; end
            K_OPI:   begin b.imm = 3'd0; b.src = 2'd1; end
            default: ;
        endcase
        b.sz   = 2'(e.sz);
        b.uns  = e.uns;
        b.word = e.word;
        return b;
    endfunction

    function automatic bit m_ready(input int k);
        return (m_st[k] == 0) && !flush && (!m_v[k] || id_ready);
    endfunction

    task automatic model_edge(input int k);
        int j;
        bit acc;
        if (rst) begin
            m_st[k] = 0; m_v[k] = 0; m_b[k] = '0; m_ti[k] = '0;
        end else begin
            acc = if_valid && m_ready(k);
            if (acc) begin
                j = lookup(if_inst, (k == 0) ? 64 : 32);
                if (j < 0) begin
                    m_st[k] = 2; m_ti[k] = if_inst; m_v[k] = 0;
                end else begin
                    m_b[k] = expect_of(tab[j], if_inst, (k == 0) ? if_pc : {32'd0, if_pc[31:0]});
                    m_v[k] = 1;
                    if (tab[j].kind == K_EBRK) m_st[k] = 1;
                end
            end else if (flush || id_ready) begin
                m_v[k] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check handshake, advance model, check registered outputs
    task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic rdy, input logic fl, input logic r);
        logic [34:0] ctl_o, ctl_e;
        rst = r; if_valid = v; if_inst = inst; if_pc = pc; id_ready = rdy; flush = fl;
        #1;
        if (known) begin
            chk("if_ready64", 128'(a_if_ready), 128'(m_ready(0)));
            chk("if_ready32", 128'(b_if_ready), 128'(m_ready(1)));
        end
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        if (r) known = 1;
        @(negedge clk);
        if (known) begin
            for (int k = 0; k < 2; k++) begin
                ctl_o = (k == 0) ? {a_id_valid, a_halt, a_trap, a_trap_inst}
                                 : {b_id_valid, b_halt, b_trap, b_trap_inst};
                ctl_e = {m_v[k], m_st[k] == 1, m_st[k] == 2, m_ti[k]};
                chk($sformatf("ctl%0d", k), 128'(ctl_o), 128'(ctl_e));
                chk($sformatf("bundle%0d", k), 128'((k == 0) ? o_a : o_b), 128'(m_b[k]));
            end
        end
    endtask

    function automatic logic [31:0] rand_inst();
        int idx;
        logic [31:0] r;
        if ($urandom_range(0, 99) < 3) return $urandom;
        do idx = $urandom_range(0, tab.size() - 1);
        while ((tab[idx].xl == 64 || tab[idx].kind == K_EBRK) && $urandom_range(0, 3) != 0);
        r = $urandom;
        return (tab[idx].match & tab[idx].mask) | (r & ~tab[idx].mask);
    endfunction

    initial begin
        logic [31:0] s[4];
        bit rp[8];
        int pi;
        bit acc;
        build_table();
        s = '{32'h002081b3, 32'h40208233, 32'h00113023, 32'h00013283};
        rp = '{1, 0, 0, 1, 1, 1, 1, 1};

        // Reset, then addi x1,x0,5
        step(0, 32'h0, 64'h0, 1, 0, 1);
        step(0, 32'h0, 64'h0, 1, 0, 1);
        chk("rst_valid", 128'(a_id_valid), 128'(0));
        step(1, 32'h00500093, 64'h8000_0000, 1, 0, 0);
        chk("addi_valid", 128'(a_id_valid), 128'(1));
        chk("addi_rd", 128'(a_rd), 128'(1));
        chk("addi_wen", 128'(a_wen), 128'(1));
        chk("addi_alu", 128'(a_alu), 128'(0));
        chk("addi_src", 128'(a_src), 128'(1));
        chk("addi_imm", 128'(a_imm), 128'(0));

        // add/sub/sd/ld stream with stalls; RV32 instance traps on sd
        pi = 0;
        for (int c = 0; c < 8; c++) begin
            acc = (m_st[0] == 0) && (!m_v[0] || rp[c]) && (pi < 4);
            step(pi < 4, (pi < 4) ? s[pi] : 32'h0, 64'h1000 + 64'(4 * pi), rp[c], 0, 0);
            if (acc && pi == 2) begin
                chk("sd_mwen", 128'(a_mwen), 128'(1));
                chk("sd_size", 128'(a_sz), 128'(3));
                chk("sd32_trap", 128'(b_trap), 128'(1));
                chk("sd32_tinst", 128'(b_trap_inst), 128'(32'h00113023));
            end
            if (acc) pi++;
        end
        chk("sd32_valid", 128'(b_id_valid), 128'(0));

        // ebreak halts; later fetches are refused; reset recovers
        step(0, 32'h0, 64'h0, 1, 0, 1);
        step(1, 32'h00100073, 64'h2000, 0, 0, 0);
        chk("ebreak_halt", 128'(a_halt), 128'(1));
        chk("ebreak_valid", 128'(b_id_valid), 128'(1));
        chk("ebreak_enables", 128'({a_wen, a_ren, a_mwen, a_br, a_jmp}), 128'(0));
        for (int c = 0; c < 3; c++) step(1, 32'h00500093, 64'h2004, 1, 0, 0);
        chk("halt_ready", 128'(a_if_ready), 128'(0));
        step(0, 32'h0, 64'h0, 1, 0, 1);
        chk("halt_rst", 128'({a_halt, a_id_valid, a_pc}), 128'(0));

        // flush while stalled with a fetch pending
        step(1, 32'h00500093, 64'h3000, 0, 0, 0);
        step(1, 32'h002081b3, 64'h3004, 0, 1, 0);
        chk("flush_valid", 128'(a_id_valid), 128'(0));
        step(1, 32'h002081b3, 64'h3004, 0, 0, 0);
        chk("post_flush_rd", 128'({a_id_valid, a_rd}), 128'({1'b1, 5'd3}));

        // rd==0 write suppression, RV64 wide shamt, slliw with imm[5] set
        step(1, 32'h00100013, 64'h4000, 1, 0, 0);
        chk("x0_wen", 128'({a_wen, a_rd}), 128'(0));
        step(1, 32'h02009093, 64'h4004, 1, 0, 0);
        chk("slli32_alu", 128'({a_id_valid, a_alu}), 128'({1'b1, 4'd5}));
        chk("slli32_rv32", 128'(b_trap), 128'(1));
        step(0, 32'h0, 64'h0, 1, 0, 1);
        step(1, 32'h0200909b, 64'h5000, 1, 0, 0);
        chk("slliw_trap", 128'({a_trap, a_trap_inst}), 128'({1'b1, 32'h0200909b}));

        // Randomized traffic against the model
        step(0, 32'h0, 64'h0, 1, 0, 1);
        for (int n = 0; n < 1500; n++) begin
            logic r;
            r = ($urandom_range(0, 99) < 2) || (m_st[0] != 0 && m_st[1] != 0 && $urandom_range(0, 3) == 0);
            step($urandom_range(0, 9) < 8, rand_inst(), {$urandom, $urandom},
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
